// File: rtl/ps2_receiver_pkg.sv
// Shared definitions for the PS/2 receiver: FSM encoding, default
// filter/timeout constants and the frame parity rule.
package ps2_receiver_pkg;

  localparam int DEFAULT_FILTER_LEN     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 5000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // A PS/2 frame is valid when the 8 data bits plus the parity bit hold an
  // odd number of ones.
  function automatic logic frame_parity_ok(input logic [7:0] data_byte,
                                           input logic       parity_bit);
    return ^{data_byte, parity_bit};
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronizes the raw PS/2 clock and data lines into the i_clk domain,
// deglitches the PS/2 clock and produces a one-cycle strobe on each
// accepted falling edge of the filtered clock.
module ps2_input_filter
  import ps2_receiver_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_data,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_clk;
  logic [CW-1:0] run_cnt;

  // Synchronize both lines, then accept a PS/2 clock level change only after
  // FILTER_LEN consecutive samples disagree with the current filtered level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // Synchronizers and filter come out of reset at the idle bus level (1)
      // so releasing reset never looks like a falling edge.
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_clk  <= 1'b1;
      run_cnt   <= '0;
      o_fall    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of its neighbours; blocking here would collapse the 2-flop chain.
      clk_sync  <= {clk_sync[0], i_ps2_clk};
      data_sync <= {data_sync[0], i_ps2_data};
      o_fall    <= 1'b0;
      if (clk_sync[1] == filt_clk) begin
        run_cnt <= '0;
      end else if (run_cnt == CNT_LAST) begin
        filt_clk <= clk_sync[1];
        run_cnt  <= '0;
        // Filtered level is flipping; it was 1 means this is a 1->0 edge.
        o_fall   <= filt_clk;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

  assign o_data = data_sync[1];

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: frames start/8 data/parity/stop bits on filtered
// PS/2 clock falling edges and keeps a three-byte history of accepted codes.
module ps2_receiver
  import ps2_receiver_pkg::*;
#(
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_PS2_Clk,
  input  logic        i_PS2_Data,
  output logic [23:0] o_Data,
  output logic        o_Valid,
  output logic        o_Error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [TW-1:0] to_cnt;
  logic          ps2_data;
  logic          ps2_fall;

  ps2_input_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ps2_clk  (i_PS2_Clk),
    .i_ps2_data (i_PS2_Data),
    .o_data     (ps2_data),
    .o_fall     (ps2_fall)
  );

  // Frame FSM, shift register, history and one-cycle status pulses; the
  // timeout check wins over a strobe arriving in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      o_Data     <= '0;
      o_Valid    <= 1'b0;
      o_Error    <= 1'b0;
    end else begin
      o_Valid <= 1'b0;
      o_Error <= 1'b0;
      if (state != ST_IDLE && to_cnt == TO_LAST) begin
        // Abandon the partial frame silently.
        state     <= ST_IDLE;
        bit_cnt   <= '0;
        shift_reg <= '0;
        to_cnt    <= '0;
      end else begin
        if (state == ST_IDLE || ps2_fall) to_cnt <= '0;
        else                              to_cnt <= to_cnt + 1'b1;

        if (ps2_fall) begin
          case (state)
            ST_IDLE: begin
              if (!ps2_data) begin
                state   <= ST_DATA;
                bit_cnt <= '0;
              end
            end
            ST_DATA: begin
              shift_reg <= {ps2_data, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) state <= ST_PARITY;
            end
            ST_PARITY: begin
              parity_bit <= ps2_data;
              state      <= ST_STOP;
            end
            ST_STOP: begin
              if (ps2_data && frame_parity_ok(shift_reg, parity_bit)) begin
                o_Data  <= {o_Data[15:0], shift_reg};
                o_Valid <= 1'b1;
              end else begin
                o_Error <= 1'b1;
              end
              state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: stimulus pushes expected results from a
// byte-level model, an independent monitor pops and compares on every pulse.
module tb_ps2_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [23:0] o_Data;
  logic        o_Valid;
  logic        o_Error;

  int checks = 0;
  int errors = 0;
  int hp = 30;  // PS/2 half bit period in i_clk cycles

  typedef struct packed {
    logic        err;
    logic [23:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] model_hist = '0;

  ps2_receiver dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_PS2_Clk  (ps2_clk),
    .i_PS2_Data (ps2_data),
    .o_Data     (o_Data),
    .o_Valid    (o_Valid),
    .o_Error    (o_Error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data set while clock is high, device drives clock low.
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      cycles(4);
      ps2_clk = 1'b0;
      cycles(3);
      ps2_clk = 1'b1;
      cycles(hp / 2 - 7);
    end else begin
      cycles(hp / 2);
    end
    ps2_clk = 1'b0;
    cycles(hp);
    ps2_clk = 1'b1;
    cycles(hp / 2);
  endtask

  // Reference: a frame is accepted iff the stop bit is 1 and the count of
  // ones over data+parity is odd; accepted bytes enter a 3-deep history.
  task automatic expect_frame(input logic [7:0] b, input logic par, input logic stop);
    exp_t e;
    if (stop && (($countones(b) + int'(par)) % 2 == 1)) begin
      model_hist = {model_hist[15:0], b};
      e.err = 1'b0;
    end else begin
      e.err = 1'b1;
    end
    e.data = model_hist;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input bit glitch);
    expect_frame(b, par, stop);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit(par, glitch);
    ps2_bit(stop, glitch);
    ps2_data = 1'b1;
    cycles(100);
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic drain(input string name);
    cycles(50);
    check({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every output pulse must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && (o_Valid || o_Error)) begin
      check("valid_and_error_exclusive", {31'd0, o_Valid & o_Error}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%0b error=%0b data=0x%0h expected none",
                 o_Valid, o_Error, o_Data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_is_error", {31'd0, o_Error}, {31'd0, e.err});
        check("history_data", {8'd0, o_Data}, {8'd0, e.data});
      end
    end
  end

  initial begin
    logic [7:0] rb;
    int         kind;

    // Reset state
    cycles(5);
    check("reset_data", {8'd0, o_Data}, 0);
    check("reset_valid", {31'd0, o_Valid}, 0);
    check("reset_error", {31'd0, o_Error}, 0);
    rst_n = 1'b1;
    cycles(10);

    // Single frame 0x1C
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    drain("single");
    check("single_data", {8'd0, o_Data}, 32'h0000_001C);

    // Back-to-back 0x1C, 0xF0, 0x1C
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    drain("triple");
    check("triple_data", {8'd0, o_Data}, 32'h001C_F01C);

    // Parity error then stop error
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    drain("errors");
    check("errors_data_kept", {8'd0, o_Data}, 32'h001C_F01C);

    // Partial frame abandoned by timeout, then 0x45
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    cycles(6000);
    send_frame(8'h45, good_par(8'h45), 1'b1, 1'b0);
    drain("timeout");
    check("timeout_low_byte", {24'd0, o_Data[7:0]}, 32'h45);

    // Glitched clock during 0x16
    send_frame(8'h16, good_par(8'h16), 1'b1, 1'b1);
    drain("glitch");
    check("glitch_low_byte", {24'd0, o_Data[7:0]}, 32'h16);

    // Reset mid-frame, then a clean 0x16
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    rst_n = 1'b0;
    cycles(3);
    check("midreset_data", {8'd0, o_Data}, 0);
    check("midreset_valid", {31'd0, o_Valid}, 0);
    check("midreset_error", {31'd0, o_Error}, 0);
    model_hist = '0;
    rst_n = 1'b1;
    cycles(10);
    send_frame(8'h16, good_par(8'h16), 1'b1, 1'b0);
    drain("after_reset");
    check("after_reset_data", {8'd0, o_Data}, 32'h0000_0016);

    // Randomized frames with random bit rate and occasional bad frames
    for (int n = 0; n < 24; n++) begin
      rb   = 8'($urandom);
      kind = $urandom_range(0, 5);
      hp   = $urandom_range(20, 40);
      case (kind)
        0:       send_frame(rb, ~good_par(rb), 1'b1, 1'b0);
        1:       send_frame(rb, good_par(rb), 1'b0, 1'b0);
        default: send_frame(rb, good_par(rb), 1'b1, ($urandom_range(0, 3) == 0));
      endcase
    end
    drain("random");
    check("random_final_data", {8'd0, o_Data}, {8'd0, model_hist});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #20_000_000;
    $display("FAIL time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive identical synchronized PS/2-clock samples required to accept a level change.
REQ-002 Parameter TIMEOUT_CYCLES, default 5000: idle i_clk cycles without a PS/2 falling edge after which a partial frame is abandoned.
REQ-003 Port i_clk, input, 1: system clock; all state on its rising edge.
REQ-004 Port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port i_PS2_Clk, input, 1: raw PS/2 clock line, asynchronous to i_clk.
REQ-006 Port i_PS2_Data, input, 1: raw PS/2 data line, asynchronous to i_clk.
REQ-007 Port o_Data, output, 24: history of the last three accepted scan-code bytes, with the newest byte in [7:0]; this port feeds the keyboard display stage i_Data.
REQ-008 Port o_Valid, output, 1: one-cycle pulse when o_Data has just updated.
REQ-009 Port o_Error, output, 1: one-cycle pulse on a rejected frame (start, parity or stop error).

Function
REQ-010 Both PS/2 inputs SHALL pass through a 2-flop synchronizer; the PS/2 data line SHALL be sampled from its synchronized copy.
REQ-011 Filtered PS/2 clock SHALL change level only after FILTER_LEN consecutive equal synchronized samples; shorter pulses SHALL be ignored.
REQ-012 A falling edge SHALL be a one-cycle strobe generated when filtered clock goes 1->0; latency from the raw edge is 2+FILTER_LEN cycles, ±1.
REQ-013 FSM states: IDLE, DATA, PARITY, STOP; every transition except timeout and reset occurs only on a falling-edge strobe.
REQ-014 IDLE: on a strobe, if data is 0, go to DATA with bit counter 0; if data is 1, stay in IDLE with no error.
REQ-015 DATA: shift the data bit into the byte LSB-first and increment a 3-bit counter; after the 8th bit (counter wrapping 7->0), go to PARITY.
REQ-016 PARITY: capture the bit and go to STOP; the frame parity (8 data bits plus parity) SHALL be odd.
REQ-017 STOP: if the stop bit is 1 and parity is correct, then in the next cycle o_Data <= {o_Data[15:0], byte} and o_Valid=1; otherwise o_Error=1 and o_Data is unchanged; return to IDLE either way.
REQ-018 o_Valid and o_Error SHALL never assert in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-019 A timeout counter SHALL clear on each strobe and in IDLE; outside IDLE, reaching TIMEOUT_CYCLES-1 SHALL force IDLE, discard the partial byte, and assert neither o_Valid nor o_Error.
REQ-020 A strobe arriving in the same cycle as the timeout SHALL lose; the FSM SHALL go to IDLE.
REQ-021 Break (0xF0) and extended (0xE0) bytes SHALL be treated as ordinary bytes; no decoding happens in this block.

Reset
REQ-022 While i_rst_n=0: o_Data=24'h000000, o_Valid=0, o_Error=0, FSM=IDLE, bit counter and timeout counter 0, synchronizers and filter at 1 (idle bus level).
REQ-023 Asserting reset mid-frame SHALL discard the frame; after release, the first complete frame SHALL be received correctly.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding and the default FILTER_LEN and TIMEOUT_CYCLES constants.
REQ-025 A single sub-module, ps2_input_filter, SHALL contain the synchronizers, the clock filter and the falling-edge strobe; the FSM, shift register and history SHALL live in ps2_receiver.

Verification
REQ-026 After reset, send frame 0x1C (parity 0, stop 1): exactly one o_Valid pulse, o_Data=24'h00001C, o_Error never asserts.
REQ-027 Send 0x1C, 0xF0, 0x1C back-to-back: three o_Valid pulses; final o_Data=24'h1CF01C.
REQ-028 Send 0x1C with parity bit 1, then 0x1C with stop bit 0: two o_Error pulses, no o_Valid, o_Data unchanged.
REQ-029 Send 5 bits of a frame, hold the lines high for 6000 cycles, then send 0x45: no error; o_Data[7:0]=8'h45 after one o_Valid pulse.
REQ-030 Inject 3-cycle low glitches on i_PS2_Clk during frame 0x16: the glitches are ignored and o_Data[7:0]=8'h16; pulse i_rst_n low mid-frame: outputs are 0, and the next frame 0x16 is received.
